// File: rtl/gcd_requester.sv
// Client-side driver for the GCD engine: accepts operand pairs, runs one engine
// operation at a time and returns the result with the operands echoed back.
module gcd_requester #(
  parameter int W       = 16,
  parameter int CNT_W   = 16,
  parameter int LAT_W   = 16,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  logic             gcd_idle,
  output logic             gcd_input_available,
  output logic [W-1:0]     gcd_operand_A,
  output logic [W-1:0]     gcd_operand_B,
  input  logic             gcd_result_rdy,
  input  logic [W-1:0]     gcd_result_data,
  output logic             gcd_result_taken,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic [W-1:0]     rsp_a,
  output logic [W-1:0]     rsp_b,
  output logic             busy,
  output logic [CNT_W-1:0] done_count,
  output logic [LAT_W-1:0] last_latency,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit               WD_EN   = (TIMEOUT > 0);
  localparam logic [31:0]      WD_LAST = WD_EN ? 32'(TIMEOUT - 1) : 32'd0;

  state_t           r_state;
  logic [W-1:0]     r_op_a;
  logic [W-1:0]     r_op_b;
  logic [W-1:0]     r_rsp_data;
  logic [W-1:0]     r_rsp_a;
  logic [W-1:0]     r_rsp_b;
  logic             r_req_ready;
  logic             r_busy;
  logic             r_rsp_valid;
  logic [CNT_W-1:0] r_done_count;
  logic [LAT_W-1:0] r_lat_cnt;
  logic [LAT_W-1:0] r_last_latency;
  logic [31:0]      r_wd_cnt;
  logic             r_timeout_err;
  logic             w_issue;
  logic             w_take;

  // Engine strobes must be combinational so they coincide with the engine's own idle/rdy.
  assign w_issue = (r_state == ISSUE) && gcd_idle;
  assign w_take  = (r_state == WAIT_RES) && gcd_result_rdy;

  assign req_ready           = r_req_ready;
  assign busy                = r_busy;
  assign rsp_valid           = r_rsp_valid;
  assign rsp_data            = r_rsp_data;
  assign rsp_a               = r_rsp_a;
  assign rsp_b               = r_rsp_b;
  assign gcd_input_available = w_issue;
  assign gcd_result_taken    = w_take;
  assign gcd_operand_A       = r_op_a;
  assign gcd_operand_B       = r_op_b;
  assign done_count          = r_done_count;
  assign last_latency        = r_last_latency;
  assign timeout_err         = r_timeout_err;

  // Request/issue/collect/respond sequencer with registered status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_rsp_data     <= '0;
      r_rsp_a        <= '0;
      r_rsp_b        <= '0;
      r_req_ready    <= 1'b1;
      r_busy         <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_done_count   <= '0;
      r_lat_cnt      <= '0;
      r_last_latency <= '0;
      r_wd_cnt       <= 32'd0;
      r_timeout_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && r_req_ready) begin
            r_op_a      <= req_a;
            r_op_b      <= req_b;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_issue) begin
            r_lat_cnt <= LAT_ONE;
            r_wd_cnt  <= 32'd0;
            r_state   <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (w_take) begin
            r_rsp_data     <= gcd_result_data;
            r_rsp_a        <= r_op_a;
            r_rsp_b        <= r_op_b;
            r_last_latency <= r_lat_cnt;
            r_rsp_valid    <= 1'b1;
            r_state        <= RESP;
          end else begin
            if (r_lat_cnt != LAT_MAX) begin
              r_lat_cnt <= r_lat_cnt + LAT_ONE;
            end
            // Watchdog only flags; the operation keeps waiting for a late result.
            if (WD_EN) begin
              if (r_wd_cnt >= WD_LAST) begin
                r_timeout_err <= 1'b1;
              end
              if (r_wd_cnt < WD_LAST) begin
                r_wd_cnt <= r_wd_cnt + 32'd1;
              end
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_done_count <= r_done_count + CNT_ONE;
            r_rsp_valid  <= 1'b0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_requester.sv
// Scoreboard bench for gcd_requester: a behavioural GCD engine drives two DUTs
// (default parameters and a narrow-counter/watchdog variant) with shared stimulus.
module tb_gcd_requester;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          lat;
    int          bp;
  } item_t;

  localparam int TO  = 8;
  localparam int INF = 32'h7fffffff;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [15:0] req_a, req_b;
  logic        gcd_idle;
  logic        gcd_result_rdy;
  logic [15:0] gcd_result_data;
  logic        rsp_ready;

  logic        d0_req_ready, d0_ia, d0_rt, d0_rsp_valid, d0_busy, d0_to;
  logic [15:0] d0_opa, d0_opb, d0_rsp_data, d0_rsp_a, d0_rsp_b, d0_done, d0_lat;
  logic        d1_req_ready, d1_ia, d1_rt, d1_rsp_valid, d1_busy, d1_to;
  logic [15:0] d1_opa, d1_opb, d1_rsp_data, d1_rsp_a, d1_rsp_b;
  logic [1:0]  d1_done;
  logic [3:0]  d1_lat;

  int    n_checks = 0;
  int    n_errors = 0;
  item_t sb_q[$];

  // shared between stimulus and engine model
  int cyc = 0;
  int cur_d = 0, hold_cfg = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  gcd_requester #(.W(16), .CNT_W(16), .LAT_W(16), .TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d0_req_ready),
    .req_a(req_a), .req_b(req_b), .gcd_idle(gcd_idle), .gcd_input_available(d0_ia),
    .gcd_operand_A(d0_opa), .gcd_operand_B(d0_opb), .gcd_result_rdy(gcd_result_rdy),
    .gcd_result_data(gcd_result_data), .gcd_result_taken(d0_rt), .rsp_valid(d0_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(d0_rsp_data), .rsp_a(d0_rsp_a), .rsp_b(d0_rsp_b),
    .busy(d0_busy), .done_count(d0_done), .last_latency(d0_lat), .timeout_err(d0_to)
  );

  gcd_requester #(.W(16), .CNT_W(2), .LAT_W(4), .TIMEOUT(TO)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d1_req_ready),
    .req_a(req_a), .req_b(req_b), .gcd_idle(gcd_idle), .gcd_input_available(d1_ia),
    .gcd_operand_A(d1_opa), .gcd_operand_B(d1_opb), .gcd_result_rdy(gcd_result_rdy),
    .gcd_result_data(gcd_result_data), .gcd_result_taken(d1_rt), .rsp_valid(d1_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(d1_rsp_data), .rsp_a(d1_rsp_a), .rsp_b(d1_rsp_b),
    .busy(d1_busy), .done_count(d1_done), .last_latency(d1_lat), .timeout_err(d1_to)
  );

  function automatic logic [15:0] gcd_ref(input logic [15:0] a, input logic [15:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 16'(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural engine: idle until issued, result after a chosen delay, held until taken.
  initial begin : engine
    int e_st, e_cnt, hold_cnt, acc_d, acc_hold, exp_issue, to_at, i_cyc;
    bit s_rst, s_ia, s_rt, s_acc, pend, exp_to;
    logic [15:0] s_opa, s_opb, pend_a, pend_b, e_res;
    e_st = 0; e_cnt = 0; hold_cnt = 0; acc_d = 0; acc_hold = 0; exp_issue = 0;
    to_at = INF; s_rst = 1'b0; s_ia = 1'b0; s_rt = 1'b0; s_acc = 1'b0;
    pend = 1'b0; exp_to = 1'b0; pend_a = '0; pend_b = '0; e_res = '0;
    gcd_idle = 1'b1; gcd_result_rdy = 1'b0; gcd_result_data = 16'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!s_rst) begin
        e_st = 0; gcd_idle = 1'b1; gcd_result_rdy = 1'b0; hold_cnt = 0;
        pend = 1'b0; exp_to = 1'b0; to_at = INF;
      end else begin
        if (s_acc) hold_cnt = acc_hold;
        case (e_st)
          0: begin
            if (s_ia) begin
              e_res = gcd_ref(s_opa, s_opb);
              gcd_idle = 1'b0;
              if (acc_d == 0) begin
                gcd_result_rdy = 1'b1; gcd_result_data = e_res; e_st = 2;
              end else begin
                e_cnt = acc_d - 1; e_st = 1;
              end
            end else if (hold_cnt > 0) begin
              gcd_idle = 1'b0; hold_cnt--;
            end else begin
              gcd_idle = 1'b1;
            end
          end
          1: begin
            if (e_cnt == 0) begin
              gcd_result_rdy = 1'b1; gcd_result_data = e_res; e_st = 2;
            end else begin
              e_cnt--;
            end
          end
          default: begin
            if (s_rt) begin
              gcd_result_rdy = 1'b0; gcd_result_data = 16'd0; e_st = 0; gcd_idle = 1'b1;
            end
          end
        endcase
        if (cyc >= to_at) exp_to = 1'b1;
      end
      #1;
      s_rst = reset; s_ia = d0_ia; s_rt = d0_rt; s_opa = d0_opa; s_opb = d0_opb;
      s_acc = reset && req_valid && d0_req_ready;
      if (cyc > 3) begin
        check("issue_timing0", 32'(d0_ia), 32'(pend && (cyc == exp_issue)));
        check("issue_timing1", 32'(d1_ia), 32'(pend && (cyc == exp_issue)));
        check("taken0", 32'(d0_rt), 32'(e_st == 2));
        check("taken1", 32'(d1_rt), 32'(e_st == 2));
        check("timeout0", 32'(d0_to), 32'd0);
        check("timeout1", 32'(d1_to), 32'(exp_to));
      end
      if (s_ia && s_rst) begin
        check("operand_a", 32'(d0_opa), 32'(pend_a));
        check("operand_b", 32'(d1_opb), 32'(pend_b));
        i_cyc = cyc;
        to_at = (acc_d >= TO) ? i_cyc + TO + 1 : INF;
        pend = 1'b0;
      end
      if (s_acc) begin
        pend = 1'b1; pend_a = req_a; pend_b = req_b;
        acc_d = cur_d; acc_hold = hold_cfg;
        exp_issue = cyc + 1 + acc_hold;
      end
    end
  end

  // Downstream sink and scoreboard checker.
  initial begin : monitor
    int stall;
    bit m_hs, m_rst;
    item_t it;
    stall = 0; m_hs = 1'b0; m_rst = 1'b1; rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (m_rst) begin
        exp_cnt = 0; stall = 0;
      end else if (m_hs) begin
        exp_cnt++; stall = 0;
      end
      if (d0_rsp_valid && sb_q.size() > 0 && stall < sb_q[0].bp) begin
        rsp_ready = 1'b0; stall++;
      end else begin
        rsp_ready = d0_rsp_valid;
      end
      #1;
      m_rst = !reset;
      m_hs  = reset && d0_rsp_valid && rsp_ready;
      if (cyc > 3) begin
        check("done_count0", 32'(d0_done), 32'(exp_cnt % 65536));
        check("done_count1", 32'(d1_done), 32'(exp_cnt % 4));
      end
      if (d0_rsp_valid && reset) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", 32'(d0_rsp_valid), 32'd0);
        end else begin
          it = sb_q[0];
          check("rsp_data0", 32'(d0_rsp_data), 32'(it.res));
          check("rsp_a0", 32'(d0_rsp_a), 32'(it.a));
          check("rsp_b0", 32'(d0_rsp_b), 32'(it.b));
          check("rsp_valid1", 32'(d1_rsp_valid), 32'd1);
          check("rsp_data1", 32'(d1_rsp_data), 32'(it.res));
          check("req_ready_in_resp", 32'(d0_req_ready), 32'd0);
          if (m_hs) begin
            check("last_latency0", 32'(d0_lat), 32'(it.lat));
            check("last_latency1", 32'(d1_lat), 32'((it.lat > 15) ? 15 : it.lat));
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  task automatic send(input int a, input int b, input int d, input int hold, input int bp);
    int w;
    item_t it;
    @(negedge clk);
    cur_d = d; hold_cfg = hold;
    req_a = 16'(a); req_b = 16'(b); req_valid = 1'b1;
    #1;
    w = 0;
    while (!d0_req_ready && w < 500) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!d0_req_ready) begin
      check("accept_timeout", 32'(d0_req_ready), 32'd1);
    end else begin
      it.a = 16'(a); it.b = 16'(b); it.res = gcd_ref(it.a, it.b);
      it.lat = d + 1; it.bp = bp;
      sb_q.push_back(it);
    end
  endtask

  task automatic drain();
    int w;
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (sb_q.size() > 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin : stim
    int k;
    reset = 1'b0; req_valid = 1'b1; req_a = 16'd3; req_b = 16'd9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    check("rst_req_ready", 32'(d0_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(d0_rsp_valid), 32'd0);
    check("rst_busy", 32'(d0_busy), 32'd0);
    check("rst_input_avail", 32'(d0_ia), 32'd0);
    check("rst_result_taken", 32'(d0_rt), 32'd0);
    check("rst_done_count", 32'(d0_done), 32'd0);
    check("rst_timeout", 32'(d1_to), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    send(27, 15, 4, 0, 10);
    send(8, 12, 3, 0, 0);
    send(40, 24, 2, 5, 1);
    send(0, 0, 0, 0, 0);
    send(65535, 1, 1, 0, 0);
    send(49, 21, 20, 0, 2);
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(1, 40);
      send(k * $urandom_range(0, 1500), k * $urandom_range(0, 1500),
           $urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    drain();

    // Reset while the engine is still computing: the operation must vanish.
    send(100, 75, 30, 0, 0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    check("busy_before_reset", 32'(d0_busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("post_rst_rsp_valid", 32'(d0_rsp_valid), 32'd0);
    check("post_rst_busy", 32'(d0_busy), 32'd0);
    check("post_rst_req_ready", 32'(d1_req_ready), 32'd1);
    repeat (10) @(negedge clk);

    send(6, 4, 1, 0, 0);
    drain();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
